// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ memory responder.
//   WORD_W      default data/address width
//   ld_state_e  loader state: LOAD (accepting the program) or RUN (core owns memory)
package subleq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ld_state_e;

endpackage

// File: rtl/subleq_mem_loader.sv
// Program loader for the SUBLEQ memory responder.
// After reset it accepts a stream of words and writes them to consecutive
// array indices from 0. The word marked last ends loading and raises run.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   ld_valid_i      loader word valid
//   ld_data_i       loader word
//   ld_last_i       final word of the program (qualified by ld_valid_i)
//   ld_ready_o      loader can accept a word (registered)
//   run_o           loading complete (registered)
//   ld_we_o         array write request for the accepted word
//   ld_idx_o        array index of the accepted word
//   ld_wdata_o      data of the accepted word
//   state_o         current loader state (1 = RUN), for observation
//
// Handshake: a word transfers on every rising edge where ld_valid_i and
// ld_ready_o are both high; ld_data_i/ld_last_i are only meaningful then.
// ld_ready_o does not depend combinationally on ld_valid_i.
module subleq_mem_loader
  import subleq_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int AW     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_valid_i,
  input  logic [WORD_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              run_o,
  output logic              ld_we_o,
  output logic [AW-1:0]     ld_idx_o,
  output logic [WORD_W-1:0] ld_wdata_o,
  output logic              state_o
);

  ld_state_e         state_q;
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     ptr_d;
  logic              ready_q;
  logic              run_q;
  logic              accept;

  // ready_q is only ever high in LOAD, so it alone qualifies acceptance.
  // A word offered in the reset cycle is never written.
  assign accept = ld_valid_i & ready_q & ~rst_i;
  assign ptr_d  = ptr_q + 1'b1;   // wraps naturally at DEPTH

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          ready_q <= 1'b1;
          if (accept) begin
            ptr_q <= ptr_d;
            if (ld_last_i) begin
              state_q <= RUN;
              ready_q <= 1'b0;
              run_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          // Loader inputs are ignored until the next reset.
          ready_q <= 1'b0;
          run_q   <= 1'b1;
        end
        default: begin
          state_q <= LOAD;
          ready_q <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready_o = ready_q;
  assign run_o      = run_q;
  assign ld_we_o    = accept;
  assign ld_idx_o   = ptr_q;
  assign ld_wdata_o = ld_data_i;
  assign state_o    = (state_q == RUN);

endmodule

// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the SUBLEQ core: two request ports (both
// read/write capable) onto one word array, fixed 2-cycle read latency, and a
// built-in program loader that fills the array after reset.
//
// Ports:
//   clock, rst                    clock, synchronous active-high reset
//   en_1/we_1/addr_1/din_1        port 1 request, write enable, address, data
//   dout_1                        port 1 read data (2 cycles after issue)
//   en_2/we_2/addr_2/din_2        port 2 request, write enable, address, data
//   dout_2                        port 2 read data (2 cycles after issue)
//   ld_valid/ld_data/ld_last      loader stream (valid/ready)
//   ld_ready                      loader can accept a word
//   run                           loading complete; core may execute
//
// Addresses wrap modulo DEPTH: only the low AW bits index the array.
// Any enabled request (read or write) issues a read of its index; a write
// therefore returns its own new data two cycles later.
module subleq_mem_responder #(
  parameter int WORD_W = subleq_pkg::WORD_W,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en_1,
  input  logic              we_1,
  input  logic [WORD_W-1:0] addr_1,
  input  logic [WORD_W-1:0] din_1,
  output logic [WORD_W-1:0] dout_1,
  input  logic              en_2,
  input  logic              we_2,
  input  logic [WORD_W-1:0] addr_2,
  input  logic [WORD_W-1:0] din_2,
  output logic [WORD_W-1:0] dout_2,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              run
);

  import subleq_pkg::*;

  localparam int AW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  logic              ld_we;
  logic [AW-1:0]     ld_idx;
  logic [WORD_W-1:0] ld_wdata;
  logic              ld_state;

  subleq_mem_loader #(
    .WORD_W (WORD_W),
    .AW     (AW)
  ) u_loader (
    .clk_i      (clock),
    .rst_i      (rst),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .run_o      (run),
    .ld_we_o    (ld_we),
    .ld_idx_o   (ld_idx),
    .ld_wdata_o (ld_wdata),
    .state_o    (ld_state)
  );

  // ---------------------------------------------------------------------------
  // Write arbitration: loader > port 1 > port 2
  // ---------------------------------------------------------------------------
  logic          in_run;
  logic [AW-1:0] idx_1;
  logic [AW-1:0] idx_2;
  logic          p1_wr;
  logic          p2_wr;

  assign in_run = (ld_state_e'(ld_state) == RUN);
  assign idx_1  = addr_1[AW-1:0];
  assign idx_2  = addr_2[AW-1:0];

  // Port writes only land in RUN, and never in a reset cycle.
  assign p1_wr = en_1 & we_1 & in_run & ~rst;
  assign p2_wr = en_2 & we_2 & in_run & ~rst;

  // Upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_1[WORD_W-1:AW], addr_2[WORD_W-1:AW]};

  // ---------------------------------------------------------------------------
  // Array (no reset; contents survive rst)
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (ld_we) begin
      mem_q[ld_idx] <= ld_wdata;
    end else begin
      // Port 1 is assigned last so it wins a same-index collision.
      if (p2_wr) mem_q[idx_2] <= din_2;
      if (p1_wr) mem_q[idx_1] <= din_1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipelines
  // Stage 1 captures the index at the end of the issue cycle; stage 2 reads
  // the array one cycle later. Because the array read happens after the
  // issue-cycle write has committed, a read issued in the same cycle as a
  // write to its index already returns the new data (write-first).
  // ---------------------------------------------------------------------------
  logic              rd1_v_q;
  logic [AW-1:0]     rd1_idx_q;
  logic [WORD_W-1:0] dout1_q;
  logic              rd2_v_q;
  logic [AW-1:0]     rd2_idx_q;
  logic [WORD_W-1:0] dout2_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      rd1_v_q   <= 1'b0;
      rd1_idx_q <= '0;
      dout1_q   <= '0;
      rd2_v_q   <= 1'b0;
      rd2_idx_q <= '0;
      dout2_q   <= '0;
    end else begin
      rd1_v_q <= en_1;
      rd2_v_q <= en_2;
      if (en_1) rd1_idx_q <= idx_1;
      if (en_2) rd2_idx_q <= idx_2;
      // A bubble leaves the output register untouched.
      if (rd1_v_q) dout1_q <= mem_q[rd1_idx_q];
      if (rd2_v_q) dout2_q <= mem_q[rd2_idx_q];
    end
  end

  assign dout_1 = dout1_q;
  assign dout_2 = dout2_q;

endmodule

// File: tb/tb_subleq_mem_responder.sv
module tb_subleq_mem_responder;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic         clock;
  logic         rst;
  logic         en_1, we_1, en_2, we_2;
  logic [W-1:0] addr_1, din_1, dout_1, addr_2, din_2, dout_2;
  logic         ld_valid, ld_last, ld_ready, run;
  logic [W-1:0] ld_data;

  subleq_mem_responder #(.WORD_W(W), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .rst      (rst),
    .en_1     (en_1),
    .we_1     (we_1),
    .addr_1   (addr_1),
    .din_1    (din_1),
    .dout_1   (dout_1),
    .en_2     (en_2),
    .we_2     (we_2),
    .addr_2   (addr_2),
    .din_2    (din_2),
    .dout_2   (dout_2),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .run      (run)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: memory image, loader status, per-port read scoreboards
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_mem [DEPTH];
  bit           m_known [DEPTH];
  bit           m_run, m_ready;
  int           m_ptr;

  logic [W-1:0] exp_q1[$], exp_q2[$];
  bit           kn_q1[$], kn_q2[$];
  int           due_q1[$], due_q2[$];
  logic [W-1:0] exp_d1, exp_d2;
  bit           kn_d1, kn_d2;

  int cyc;
  int n_checks;
  int n_pass;

  logic [W-1:0] ld_words[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  task automatic ports_idle();
    en_1 = 0; we_1 = 0; addr_1 = '0; din_1 = '0;
    en_2 = 0; we_2 = 0; addr_2 = '0; din_2 = '0;
  endtask

  task automatic loader_idle();
    ld_valid = 0; ld_data = '0; ld_last = 0;
  endtask

  // Small index set (so reads hit written words and ports collide) with
  // random upper address bits to exercise wrap-around.
  function automatic logic [W-1:0] rand_addr();
    logic [W-1:0] hi;
    hi = ($urandom_range(0, 3) == 0) ? ($urandom() & ~(W'(DEPTH - 1))) : '0;
    return hi | W'($urandom_range(0, 15));
  endfunction

  task automatic rand_ports();
    en_1 = 1'($urandom_range(0, 1)); we_1 = 1'($urandom_range(0, 1));
    addr_1 = rand_addr(); din_1 = $urandom();
    en_2 = 1'($urandom_range(0, 1)); we_2 = 1'($urandom_range(0, 1));
    addr_2 = rand_addr(); din_2 = $urandom();
  endtask

  // Apply the spec's rules for the coming edge to the model, clock the DUT,
  // then compare every observable output.
  task automatic step();
    int i1, i2;
    bit acc;
    i1 = int'(addr_1[AW-1:0]);
    i2 = int'(addr_2[AW-1:0]);
    if (rst) begin
      m_run = 0; m_ready = 0; m_ptr = 0;
      exp_q1.delete(); kn_q1.delete(); due_q1.delete();
      exp_q2.delete(); kn_q2.delete(); due_q2.delete();
      exp_d1 = '0; exp_d2 = '0; kn_d1 = 1; kn_d2 = 1;
    end else begin
      acc = ld_valid && m_ready;
      if (acc) begin
        m_mem[m_ptr] = ld_data; m_known[m_ptr] = 1;
      end else if (m_run) begin
        if (en_2 && we_2) begin m_mem[i2] = din_2; m_known[i2] = 1; end
        if (en_1 && we_1) begin m_mem[i1] = din_1; m_known[i1] = 1; end
      end
      if (en_1) begin exp_q1.push_back(m_mem[i1]); kn_q1.push_back(m_known[i1]); due_q1.push_back(cyc + 2); end
      if (en_2) begin exp_q2.push_back(m_mem[i2]); kn_q2.push_back(m_known[i2]); due_q2.push_back(cyc + 2); end
      if (!m_run) begin
        if (acc) m_ptr = (m_ptr + 1) % DEPTH;
        if (acc && ld_last) begin m_run = 1; m_ready = 0; end
        else m_ready = 1;
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    while (due_q1.size() > 0 && due_q1[0] <= cyc) begin
      exp_d1 = exp_q1.pop_front(); kn_d1 = kn_q1.pop_front(); void'(due_q1.pop_front());
    end
    while (due_q2.size() > 0 && due_q2[0] <= cyc) begin
      exp_d2 = exp_q2.pop_front(); kn_d2 = kn_q2.pop_front(); void'(due_q2.pop_front());
    end
    check_eq("run", W'(run), W'(m_run));
    check_eq("ld_ready", W'(ld_ready), W'(m_ready));
    if (kn_d1) check_eq("dout_1", dout_1, exp_d1);
    if (kn_d2) check_eq("dout_2", dout_2, exp_d2);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) rand_ports(); else ports_idle();
      step();
    end
    rst = 0;
    ports_idle();
  endtask

  // Stream ld_words with random idle gaps; mark_last tags the final word.
  task automatic load_words(input bit mark_last, input bit noise);
    int budget;
    bit was_ready;
    for (int k = 0; k < ld_words.size(); k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        loader_idle();
        if (noise) rand_ports();
        step();
      end
      ld_valid = 1;
      ld_data  = ld_words[k];
      ld_last  = mark_last && (k == ld_words.size() - 1);
      budget   = 0;
      do begin
        if (noise) rand_ports();
        was_ready = m_ready;
        step();
        budget++;
      end while (!was_ready && budget < 8);
      if (!was_ready) check_eq("ld_accept_timeout", 0, 1);
    end
    loader_idle();
    ports_idle();
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      rand_ports();
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = $urandom();
      ld_last  = 1'($urandom_range(0, 1));
      step();
    end
    loader_idle();
    ports_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] t1_vals[5];
    cyc = 0; n_checks = 0; n_pass = 0;
    m_run = 0; m_ready = 0; m_ptr = 0;
    kn_d1 = 0; kn_d2 = 0; exp_d1 = '0; exp_d2 = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    rst = 1;
    ports_idle();
    loader_idle();

    do_reset(2);
    check_eq("reset_dout_1", dout_1, 0);
    check_eq("reset_dout_2", dout_2, 0);
    check_eq("reset_run", W'(run), 0);

    // Load {7,8,9,0,3}, then read them back on port 2.
    t1_vals = '{32'd7, 32'd8, 32'd9, 32'd0, 32'd3};
    ld_words = '{32'd7, 32'd8, 32'd9, 32'd0, 32'd3};
    load_words(1, 0);
    check_eq("t1_run_after_last", W'(run), 1);
    for (int i = 0; i < 7; i++) begin
      en_2 = (i < 5); addr_2 = W'(i);
      step();
      if (i >= 1 && i <= 5) check_eq("t1_rd", dout_2, t1_vals[i-1]);
    end
    ports_idle();

    // Back-to-back reads 0,1,2 on port 2.
    for (int i = 0; i < 5; i++) begin
      en_2 = (i < 3); addr_2 = W'(i);
      step();
      if (i >= 1 && i <= 3) check_eq("t2_rd", dout_2, t1_vals[i-1]);
    end
    ports_idle();

    // Port 1 writes index 10 while port 2 reads it in the same cycle.
    en_1 = 1; we_1 = 1; addr_1 = 32'd10; din_1 = 32'hFFFF_FFFE;
    en_2 = 1; we_2 = 0; addr_2 = 32'd10;
    step();
    ports_idle();
    step();
    check_eq("t3_write_first", dout_2, 32'hFFFF_FFFE);

    // Both ports write index 4; port 1 must win.
    en_1 = 1; we_1 = 1; addr_1 = 32'd4; din_1 = 32'h11;
    en_2 = 1; we_2 = 1; addr_2 = 32'd4; din_2 = 32'h22;
    step();
    ports_idle();
    en_2 = 1; addr_2 = 32'd4;
    step();
    ports_idle();
    step();
    check_eq("t4_collision", dout_2, 32'h11);

    // Address wrap and output hold during bubbles.
    en_1 = 1; we_1 = 1; addr_1 = 32'd3; din_1 = 32'h5A5A_0003;
    step();
    en_1 = 1; we_1 = 0; addr_1 = 32'(DEPTH + 3);
    step();
    ports_idle();
    step();
    check_eq("t5_wrap", dout_1, 32'h5A5A_0003);
    for (int i = 0; i < 3; i++) begin
      addr_1 = rand_addr();
      step();
      check_eq("t5_hold", dout_1, 32'h5A5A_0003);
    end

    rand_run(300);

    // Reset mid-load, then reload a short program.
    do_reset(1);
    ld_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    ld_words = ld_words[0:1];
    load_words(0, 0);
    check_eq("t6_run_mid_load", W'(run), 0);
    do_reset(1);
    check_eq("t6_run_after_rst", W'(run), 0);
    check_eq("t6_dout_1_after_rst", dout_1, 0);
    check_eq("t6_dout_2_after_rst", dout_2, 0);
    ld_words = '{32'd1, 32'd2};
    load_words(1, 0);
    check_eq("t6_run_reload", W'(run), 1);
    en_1 = 1; addr_1 = 32'd0; en_2 = 1; addr_2 = 32'd1;
    step();
    ports_idle();
    step();
    check_eq("t6_mem0", dout_1, 32'd1);
    check_eq("t6_mem1", dout_2, 32'd2);

    // Randomized reload/run rounds with port noise during loading.
    for (int r = 0; r < 3; r++) begin
      do_reset($urandom_range(1, 3));
      ld_words.delete();
      for (int k = $urandom_range(3, 12); k > 0; k--) ld_words.push_back($urandom());
      load_words(1, 1);
      rand_run(150);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
